nukv_request_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges up to NUM_PORTS independent 128-bit request streams into the single stream feeding nukv_RequestSplit. Each packet is forwarded whole and is never interleaved with another. Each output beat is tagged with its source port so responses can be routed back. A beat-count watchdog truncates runaway packets, so one malformed source cannot stall the splitter.

---
 rtl/nukv_pkg.sv | 19 +
 rtl/nukv_rr_pick.sv | 34 +++
 rtl/nukv_request_arbiter.sv | 143 ++++++++++++++
 tb/tb_nukv_request_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nukv_pkg.sv
// Shared definitions for the nukv request path: arbiter states, request width, defaults.
// Combinational helpers only; no state lives here.
package nukv_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int REQ_W             = 128;
  localparam int DEFAULT_MAX_BEATS = 512;

  // Round-robin successor of a port index, wrapping at n-1.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/nukv_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping; purely combinational.
// Zero latency; no backpressure (the caller decides when to act on o_hit).
module nukv_rr_pick
  import nukv_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [ID_WIDTH-1:0]  i_ptr,
  output logic [ID_WIDTH-1:0]  o_idx,
  output logic                 o_hit
);

  int w_best_d;
  int w_d;

  // Smallest forward distance from the pointer wins.
  always_comb begin
    o_idx    = '0;
    o_hit    = 1'b0;
    w_best_d = NUM_PORTS;
    w_d      = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_d = (j + NUM_PORTS - int'(i_ptr)) % NUM_PORTS;
      if (i_req[j] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        o_idx    = ID_WIDTH'(j);
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nukv_request_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS request streams, with source tagging and overlength truncation.
// One-cycle latency via output register; stalls only through in_ready, except draining which ignores the output.
module nukv_request_arbiter
  import nukv_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*REQ_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]       s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]       s_axis_tlast,
  output logic [NUM_PORTS-1:0]       s_axis_tready,
  output logic [REQ_W-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [ID_WIDTH-1:0]        m_axis_tid,
  input  logic                       m_axis_tready,
  output logic                       err_overlength,
  output logic [ID_WIDTH-1:0]        err_port
);

  logic [REQ_W-1:0]    w_port_dat [NUM_PORTS];
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] w_pick;
  logic                w_hit;
  logic [15:0]         r_beat_cnt;
  logic [REQ_W-1:0]    r_m_tdata;
  logic                r_m_tvalid;
  logic                r_m_tlast;
  logic [ID_WIDTH-1:0] r_m_tid;
  logic                r_err_ovl;
  logic [ID_WIDTH-1:0] r_err_port;
  logic                w_in_ready;
  logic                w_sel_vld;
  logic                w_sel_last;
  logic                w_rdy_sel;
  logic                w_accept;
  logic                w_trunc;
  logic                w_pkt_done;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_dat
    assign w_port_dat[gi] = s_axis_tdata[gi*REQ_W +: REQ_W];
  end

  nukv_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .i_req (s_axis_tvalid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick),
    .o_hit (w_hit)
  );

  assign w_in_ready = !r_m_tvalid || m_axis_tready;
  assign w_sel_vld  = s_axis_tvalid[r_grant];
  assign w_sel_last = s_axis_tlast[r_grant];

  always_comb begin
    w_state_nxt = r_state;
    w_rdy_sel   = 1'b0;
    w_accept    = 1'b0;
    w_trunc     = 1'b0;
    w_pkt_done  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_hit) w_state_nxt = ST_PASS;
      end
      ST_PASS: begin
        w_rdy_sel = w_in_ready;
        w_accept  = w_sel_vld && w_in_ready;
        if (w_accept) begin
          if (w_sel_last) begin
            w_pkt_done  = 1'b1;
            w_state_nxt = ST_ARB;
          end else if (r_beat_cnt == 16'(MAX_BEATS - 1)) begin
            w_trunc     = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      // Discard the rest of a truncated packet without touching the output register.
      ST_DRAIN: begin
        w_rdy_sel = 1'b1;
        if (w_sel_vld && w_sel_last) begin
          w_pkt_done  = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  assign s_axis_tready = NUM_PORTS'(w_rdy_sel) << r_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_err_ovl  <= 1'b0;
      r_err_port <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_ovl <= w_trunc;
      if ((r_state == ST_ARB) && w_hit) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end else if (w_accept && (r_beat_cnt != 16'(MAX_BEATS))) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if (w_accept) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_port_dat[r_grant];
        r_m_tlast  <= w_sel_last || w_trunc;
        r_m_tid    <= r_grant;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_trunc) r_err_port <= r_grant;
      if (w_pkt_done) r_rr_ptr <= ID_WIDTH'(rr_next(int'(r_grant), NUM_PORTS));
    end
  end

  assign m_axis_tdata   = r_m_tdata;
  assign m_axis_tvalid  = r_m_tvalid;
  assign m_axis_tlast   = r_m_tlast;
  assign m_axis_tid     = r_m_tid;
  assign err_overlength = r_err_ovl;
  assign err_port       = r_err_port;

endmodule

// File: tb/tb_nukv_request_arbiter.sv
// Directed bench for nukv_request_arbiter with MAX_BEATS=4 so truncation is reachable.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
module tb_nukv_request_arbiter;

  localparam int NP = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*128-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic [127:0]     m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready;
  logic             err_ovl;
  logic [IW-1:0]    err_prt;

  int n_checks = 0;
  int n_pass   = 0;

  nukv_request_arbiter #(
    .NUM_PORTS (NP),
    .ID_WIDTH  (IW),
    .MAX_BEATS (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tid     (m_tid),
    .m_axis_tready  (m_tready),
    .err_overlength (err_ovl),
    .err_port       (err_prt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dv(input int p, input int k);
    return {96'h0, 16'hCAFE, 8'(p), 8'(k)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] rdy, input logic vld,
                         input logic lst, input logic [1:0] tid, input logic [127:0] dat,
                         input logic err);
    check({tag, ".rdy"}, 128'(s_tready), 128'(rdy));
    check({tag, ".vld"}, 128'(m_tvalid), 128'(vld));
    check({tag, ".err"}, 128'(err_ovl), 128'(err));
    if (vld) begin
      check({tag, ".last"}, 128'(m_tlast), 128'(lst));
      check({tag, ".tid"}, 128'(m_tid), 128'(tid));
      check({tag, ".dat"}, m_tdata, dat);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic l, input int k);
    s_tvalid[p] = v;
    s_tlast[p]  = l;
    s_tdata[p*128 +: 128] = dv(p, k);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    cyc(); cyc(); #1;
    chk_out("RST", 4'b0000, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    check("RST.last", 128'(m_tlast), 128'(0));
    check("RST.tid", 128'(m_tid), 128'(0));
    check("RST.dat", m_tdata, 128'(0));
    check("RST.eport", 128'(err_prt), 128'(0));
    rst_n = 1'b1;

    // A: lone port 1, 3 beats, pointer 0 -> 2
    cyc(); set_port(1, 1, 0, 1); #1; chk_out("A1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("A2", 4'b0010, 0, 0, 0, '0, 0);
    cyc(); set_port(1, 1, 0, 2); #1; chk_out("A3", 4'b0010, 1, 0, 1, dv(1, 1), 0);
    cyc(); set_port(1, 1, 1, 3); #1; chk_out("A4", 4'b0010, 1, 0, 1, dv(1, 2), 0);
    cyc(); set_port(1, 0, 0, 0); #1; chk_out("A5", 4'b0000, 1, 1, 1, dv(1, 3), 0);
    cyc();                       #1; chk_out("A6", 4'b0000, 0, 0, 0, '0, 0);

    // B: ports 1 and 2 contend with pointer 2: port 2 first, then 1
    cyc(); set_port(1, 1, 1, 7); set_port(2, 1, 1, 8); #1; chk_out("B1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("B2", 4'b0100, 0, 0, 0, '0, 0);
    cyc(); set_port(2, 0, 0, 0); #1; chk_out("B3", 4'b0000, 1, 1, 2, dv(2, 8), 0);
    cyc();                       #1; chk_out("B4", 4'b0010, 0, 0, 0, '0, 0);
    cyc(); set_port(1, 0, 0, 0); #1; chk_out("B5", 4'b0000, 1, 1, 1, dv(1, 7), 0);

    // D: port 3 with a 4-cycle downstream stall mid-packet
    cyc(); set_port(3, 1, 0, 1); #1; chk_out("D1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("D2", 4'b1000, 0, 0, 0, '0, 0);
    cyc(); set_port(3, 1, 0, 2); m_tready = 1'b0; #1; chk_out("D3", 4'b0000, 1, 0, 3, dv(3, 1), 0);
    cyc();                       #1; chk_out("D4", 4'b0000, 1, 0, 3, dv(3, 1), 0);
    cyc();                       #1; chk_out("D5", 4'b0000, 1, 0, 3, dv(3, 1), 0);
    cyc();                       #1; chk_out("D6", 4'b0000, 1, 0, 3, dv(3, 1), 0);
    cyc(); m_tready = 1'b1;      #1; chk_out("D7", 4'b1000, 1, 0, 3, dv(3, 1), 0);
    cyc(); set_port(3, 1, 1, 3); #1; chk_out("D8", 4'b1000, 1, 0, 3, dv(3, 2), 0);
    cyc(); set_port(3, 0, 0, 0); #1; chk_out("D9", 4'b0000, 1, 1, 3, dv(3, 3), 0);

    // C: ports 0 and 2 each stream two 2-beat packets, pointer 0
    cyc(); set_port(0, 1, 0, 1); set_port(2, 1, 0, 1); #1; chk_out("C1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("C2", 4'b0001, 0, 0, 0, '0, 0);
    cyc(); set_port(0, 1, 1, 2); #1; chk_out("C3", 4'b0001, 1, 0, 0, dv(0, 1), 0);
    cyc(); set_port(0, 1, 0, 3); #1; chk_out("C4", 4'b0000, 1, 1, 0, dv(0, 2), 0);
    cyc();                       #1; chk_out("C5", 4'b0100, 0, 0, 0, '0, 0);
    cyc(); set_port(2, 1, 1, 2); #1; chk_out("C6", 4'b0100, 1, 0, 2, dv(2, 1), 0);
    cyc(); set_port(2, 1, 0, 3); #1; chk_out("C7", 4'b0000, 1, 1, 2, dv(2, 2), 0);
    cyc();                       #1; chk_out("C8", 4'b0001, 0, 0, 0, '0, 0);
    cyc(); set_port(0, 1, 1, 4); #1; chk_out("C9", 4'b0001, 1, 0, 0, dv(0, 3), 0);
    cyc(); set_port(0, 0, 0, 0); #1; chk_out("C10", 4'b0000, 1, 1, 0, dv(0, 4), 0);
    cyc();                       #1; chk_out("C11", 4'b0100, 0, 0, 0, '0, 0);
    cyc(); set_port(2, 1, 1, 4); #1; chk_out("C12", 4'b0100, 1, 0, 2, dv(2, 3), 0);
    cyc(); set_port(2, 0, 0, 0); #1; chk_out("C13", 4'b0000, 1, 1, 2, dv(2, 4), 0);

    // E: exactly MAX_BEATS beats with tlast on the last one is not truncated
    cyc(); set_port(1, 1, 0, 1); #1; chk_out("E1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("E2", 4'b0010, 0, 0, 0, '0, 0);
    cyc(); set_port(1, 1, 0, 2); #1; chk_out("E3", 4'b0010, 1, 0, 1, dv(1, 1), 0);
    cyc(); set_port(1, 1, 0, 3); #1; chk_out("E4", 4'b0010, 1, 0, 1, dv(1, 2), 0);
    cyc(); set_port(1, 1, 1, 4); #1; chk_out("E5", 4'b0010, 1, 0, 1, dv(1, 3), 0);
    cyc(); set_port(1, 0, 0, 0); #1; chk_out("E6", 4'b0000, 1, 1, 1, dv(1, 4), 0);

    // F: 7-beat packet on port 1 truncated after 4, drained under a stall
    cyc(); set_port(1, 1, 0, 1); #1; chk_out("F1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("F2", 4'b0010, 0, 0, 0, '0, 0);
    cyc(); set_port(1, 1, 0, 2); #1; chk_out("F3", 4'b0010, 1, 0, 1, dv(1, 1), 0);
    cyc(); set_port(1, 1, 0, 3); #1; chk_out("F4", 4'b0010, 1, 0, 1, dv(1, 2), 0);
    cyc(); set_port(1, 1, 0, 4); #1; chk_out("F5", 4'b0010, 1, 0, 1, dv(1, 3), 0);
    cyc(); set_port(1, 1, 0, 5); m_tready = 1'b0; #1; chk_out("F6", 4'b0010, 1, 1, 1, dv(1, 4), 1);
    check("F6.eport", 128'(err_prt), 128'(1));
    cyc(); set_port(1, 1, 0, 6); #1; chk_out("F7", 4'b0010, 1, 1, 1, dv(1, 4), 0);
    cyc(); set_port(1, 1, 1, 7); #1; chk_out("F8", 4'b0010, 1, 1, 1, dv(1, 4), 0);
    cyc(); set_port(1, 0, 0, 0); set_port(2, 1, 1, 9); m_tready = 1'b1; #1;
    chk_out("F9", 4'b0000, 1, 1, 1, dv(1, 4), 0);
    cyc();                       #1; chk_out("F10", 4'b0100, 0, 0, 0, '0, 0);
    cyc(); set_port(2, 0, 0, 0); #1; chk_out("F11", 4'b0000, 1, 1, 2, dv(2, 9), 0);
    check("F11.eport", 128'(err_prt), 128'(1));

    // G: reset during beat 2 of a 5-beat packet, then a fresh packet
    cyc(); set_port(0, 1, 0, 1); #1; chk_out("G1", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("G2", 4'b0001, 0, 0, 0, '0, 0);
    cyc(); set_port(0, 1, 0, 2); #1; chk_out("G3", 4'b0001, 1, 0, 0, dv(0, 1), 0);
    cyc(); set_port(0, 1, 0, 3); rst_n = 1'b0; #1; chk_out("G4", 4'b0001, 1, 0, 0, dv(0, 2), 0);
    cyc(); rst_n = 1'b1; set_port(0, 0, 0, 0); #1;
    chk_out("G5", 4'b0000, 0, 0, 0, '0, 0);
    check("G5.last", 128'(m_tlast), 128'(0));
    check("G5.tid", 128'(m_tid), 128'(0));
    check("G5.dat", m_tdata, 128'(0));
    check("G5.eport", 128'(err_prt), 128'(0));
    cyc(); set_port(2, 1, 0, 5); #1; chk_out("G6", 4'b0000, 0, 0, 0, '0, 0);
    cyc();                       #1; chk_out("G7", 4'b0100, 0, 0, 0, '0, 0);
    cyc(); set_port(2, 1, 1, 6); #1; chk_out("G8", 4'b0100, 1, 0, 2, dv(2, 5), 0);
    cyc(); set_port(2, 0, 0, 0); #1; chk_out("G9", 4'b0000, 1, 1, 2, dv(2, 6), 0);
    cyc();                       #1; chk_out("G10", 4'b0000, 0, 0, 0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
